alu_iter: RTL

Parametrised successor to the core's combinational ALU. Adds a valid/ready handshake, a registered result and optional iterative RV32M multiply/divide. Sits in the execute stage between operand forwarding and writeback. Hazard logic stalls upstream on `in_ready` low and stalls writeback on `out_valid` low.

---
 rtl/alu_iter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU with a registered result; basic ops complete in one cycle.
// Define ALU_ITER_MULDIV_EN to add iterative RV32M multiply/divide (WIDTH-cycle latency).
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef ALU_ITER_MULDIV_EN
    , BUSY = 2'd2
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] basic;
  logic [SHW-1:0]   sh;

  assign sh        = b[SHW-1:0];
  assign in_ready  = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;

  always_comb begin
    basic = '0;
    case (ctr)
      5'd0:  basic = a + b;
      5'd1:  basic = a - b;
      5'd2:  basic = a << sh;
      5'd3:  basic = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd4:  basic = {{(WIDTH-1){1'b0}}, (a < b)};
      5'd5:  basic = a ^ b;
      5'd6:  basic = a | b;
      5'd7:  basic = a & b;
      5'd8:  basic = a >> sh;
      5'd9:  basic = $signed(a) >>> sh;
      5'd11: basic = a;
      5'd12: basic = b;
      default: basic = '0;
    endcase
  end

`ifdef ALU_ITER_MULDIV_EN
  // acc holds {high, low} of the product, or {remainder, dividend/quotient} when dividing.
  logic [2*WIDTH-1:0] acc_reg, acc_next, step_acc, prod_fix;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [SHW-1:0]     cnt_reg, cnt_next;
  logic [4:0]         op_reg, op_next;
  logic               negp_reg, negp_next, negr_reg, negr_next, bzero_reg, bzero_next;
  logic [WIDTH-1:0]   abs_a, abs_b, ld_x, ld_y, quo, rem, final_val;
  logic               ld_negp, ld_negr;
  logic [WIDTH:0]     sum, trial;

  always_comb begin
    abs_a   = a[WIDTH-1] ? -a : a;
    abs_b   = b[WIDTH-1] ? -b : b;
    ld_x    = a;
    ld_y    = b;
    ld_negp = 1'b0;
    ld_negr = 1'b0;
    case (ctr)
      5'd13, 5'd14: begin
        ld_x = abs_a; ld_y = abs_b; ld_negp = a[WIDTH-1] ^ b[WIDTH-1];
      end
      5'd15: begin
        ld_x = abs_a; ld_negp = a[WIDTH-1];
      end
      5'd17, 5'd19: begin
        ld_x = abs_a; ld_y = abs_b;
        ld_negp = a[WIDTH-1] ^ b[WIDTH-1];
        ld_negr = a[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    trial = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
    if (op_reg >= 5'd17)
      step_acc = trial[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      step_acc = {sum, acc_reg[WIDTH-1:1]};
    prod_fix = negp_reg ? -step_acc : step_acc;
    quo      = step_acc[WIDTH-1:0];
    rem      = step_acc[2*WIDTH-1:WIDTH];
    case (op_reg)
      5'd13:               final_val = prod_fix[WIDTH-1:0];
      5'd14, 5'd15, 5'd16: final_val = prod_fix[2*WIDTH-1:WIDTH];
      // Zero divisor already yields an all-ones magnitude; only the sign fix must be suppressed.
      5'd17, 5'd18:        final_val = bzero_reg ? '1 : (negp_reg ? -quo : quo);
      default:             final_val = negr_reg ? -rem : rem;
    endcase
  end
`endif

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
`ifdef ALU_ITER_MULDIV_EN
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    opnd_next  = opnd_reg;
    op_next    = op_reg;
    negp_next  = negp_reg;
    negr_next  = negr_reg;
    bzero_next = bzero_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if ((state_reg == DONE) && out_ready)
          state_next = IDLE;
        if (in_valid && in_ready) begin
`ifdef ALU_ITER_MULDIV_EN
          if ((ctr >= 5'd13) && (ctr <= 5'd20)) begin
            state_next = BUSY;
            cnt_next   = '0;
            op_next    = ctr;
            negp_next  = ld_negp;
            negr_next  = ld_negr;
            bzero_next = (b == '0);
            opnd_next  = (ctr >= 5'd17) ? ld_y : ld_x;
            acc_next   = {{WIDTH{1'b0}}, ((ctr >= 5'd17) ? ld_x : ld_y)};
          end else
`endif
          begin
            state_next  = DONE;
            result_next = basic;
          end
        end
      end
`ifdef ALU_ITER_MULDIV_EN
      BUSY: begin
        acc_next = step_acc;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == SHW'(WIDTH-1)) begin
          state_next  = DONE;
          result_next = final_val;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
`ifdef ALU_ITER_MULDIV_EN
      cnt_reg   <= '0;
      acc_reg   <= '0;
      opnd_reg  <= '0;
      op_reg    <= '0;
      negp_reg  <= 1'b0;
      negr_reg  <= 1'b0;
      bzero_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
`ifdef ALU_ITER_MULDIV_EN
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      opnd_reg  <= opnd_next;
      op_reg    <= op_next;
      negp_reg  <= negp_next;
      negr_reg  <= negr_next;
      bzero_reg <= bzero_next;
`endif
    end
  end
endmodule
